vga_sync_decoder: RTL and testbench
===================================

// Module: vga_sync_decoder
// PURPOSE
//  Receive-side counterpart of the VGA timing generator: samples hsync/vsync, locks to them,
//  and rebuilds the pixel H/V address plus a visible-region flag. Lets a bench or a downstream
//  capture/overlay path check generator timing in-system. Sync inputs are active-low, same clock domain.
// PARAMETERS
//  H_VISIBLE     640  visible pixels per line
//  H_TOTAL       800  pixels per line (addresses 0..H_TOTAL-1)
//  H_SYNC_START  656  first pixel with hsync low
//  H_SYNC_LEN     96  hsync low width, pixels
//  V_VISIBLE     480  visible lines per frame
//  V_TOTAL       525  lines per frame (addresses 0..V_TOTAL-1)
//  V_SYNC_START  490  first line with vsync low
//  V_SYNC_LEN      2  vsync low width, lines
//  LOCK_LINES      2  consecutive correct hsync falls required before vertical acquisition
// PORTS
//  clk          in   1   pixel clock
//  reset        in   1   synchronous, active-high
//  hsync        in   1   sync from generator, active-low
//  vsync        in   1   sync from generator, active-low
//  H_address    out  16  recovered pixel column
//  V_address    out  16  recovered line
//  locked       out  1   high in LOCKED
//  video_on     out  1   locked && H_address<H_VISIBLE && V_address<V_VISIBLE
//  frame_start  out  1   1-cycle pulse when H_address==0 && V_address==0 while locked
//  sync_err     out  1   1-cycle pulse on any sync mismatch after SEARCH
//  err_count    out  8   sync_err count, saturates at 255, cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0, state SEARCH, internal hc/vc/lock count/hsync history cleared.
//  - Internal hc/vc = position of the sample present on hsync/vsync this cycle. All outputs registered:
//    they describe the sample taken one cycle earlier (latency 1).
//  - hc advances every cycle, H_TOTAL-1 -> 0. vc advances only when hc wraps, V_TOTAL-1 -> 0.
//    Width: hc/vc 16 bit, compare against parameters unsigned.
//  - Expected levels: exp_h = ~(hc in [H_SYNC_START, H_SYNC_START+H_SYNC_LEN));
//    exp_v = ~(vc in [V_SYNC_START, V_SYNC_START+V_SYNC_LEN)).
//  - Falling edge = previous sample 1, current 0. First sample after reset counts as previous=1.
//  States:
//   SEARCH : hc/vc not tracked. On hsync falling edge: hc := H_SYNC_START for this sample, lock count 0,
//            -> H_TRACK. No checks, no sync_err.
//   H_TRACK: check hsync vs exp_h each cycle. Mismatch -> sync_err, -> SEARCH. Each hsync fall with
//            hc==H_SYNC_START increments lock count; at LOCK_LINES -> V_WAIT. vsync ignored.
//   V_WAIT : hsync still checked (mismatch -> sync_err, SEARCH). On vsync falling edge: needs hc==0,
//            else sync_err, -> SEARCH. If hc==0: vc := V_SYNC_START for this sample, -> LOCKED.
//   LOCKED : check hsync vs exp_h and vsync vs exp_v every cycle. Any mismatch -> sync_err, -> SEARCH.
//  - Outside LOCKED: H_address, V_address, locked, video_on, frame_start all driven 0.
//  - Mismatch that is also an hsync fall does not re-acquire that cycle: SEARCH needs a new fall.
//  - Simultaneous sync_err and err_count==255: pulse, count stays 255.
//  - reset mid-lock: next cycle all outputs 0, state SEARCH, err_count 0.
//  - Errors are checked only once hc is tracked. Before the first hsync fall, no sync_err.
// TESTING
//  1 Drive from VGAcontroller after reset -> locked rises within 3 lines + 1 frame; with locked high,
//    H_address/V_address equal generator addresses delayed 1 cycle; sync_err never pulses over 3 frames.
//  2 Locked, next sample at H=659 hsync forced high for 1 cycle -> sync_err 1 cycle later, locked 0,
//    err_count 1; relock after following vsync fall.
//  3 Locked, vsync low 3 lines (490..492) -> sync_err at first sample with vc==492, locked drops.
//  4 hsync period 801 (extra pixel) -> mismatch on each line, never leaves H_TRACK/SEARCH, locked stays 0.
//  5 In V_WAIT, vsync fall at hc==5 -> sync_err, state SEARCH; a correct fall later then locks.
//  6 Locked, V_address 479->480 -> video_on low from H=640 onward; frame_start pulses once per 420000 clocks.
//  7 Force 300 errors -> err_count saturates at 255; reset -> all outputs 0 next cycle.

Source files
------------

// File: rtl/vga_sync_decoder_if.sv
`default_nettype none
// ============================================================================
// vga_sync_decoder_if : sync inputs and recovered timing outputs of vga_sync_decoder
// Revision 1.0
// ============================================================================
interface vga_sync_decoder_if;
   logic        hsync;
   logic        vsync;
   logic [15:0] H_address;
   logic [15:0] V_address;
   logic        locked;
   logic        video_on;
   logic        frame_start;
   logic        sync_err;
   logic [7:0]  err_count;

   modport master (
      output hsync,
      output vsync,
      input  H_address,
      input  V_address,
      input  locked,
      input  video_on,
      input  frame_start,
      input  sync_err,
      input  err_count
   );

   modport slave (
      input  hsync,
      input  vsync,
      output H_address,
      output V_address,
      output locked,
      output video_on,
      output frame_start,
      output sync_err,
      output err_count
   );
endinterface
`default_nettype wire

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// vga_sync_decoder : locks to active-low VGA syncs and rebuilds H/V pixel address
// Revision 1.0
// ============================================================================
module vga_sync_decoder #(
   parameter int H_VISIBLE    = 640,
   parameter int H_TOTAL      = 800,
   parameter int H_SYNC_START = 656,
   parameter int H_SYNC_LEN   = 96,
   parameter int V_VISIBLE    = 480,
   parameter int V_TOTAL      = 525,
   parameter int V_SYNC_START = 490,
   parameter int V_SYNC_LEN   = 2,
   parameter int LOCK_LINES   = 2
) (
   input  logic              clk,
   input  logic              reset,
   vga_sync_decoder_if.slave bus
);

   localparam logic [15:0] c_h_visible  = 16'(H_VISIBLE);
   localparam logic [15:0] c_h_last     = 16'(H_TOTAL - 1);
   localparam logic [15:0] c_hs_start   = 16'(H_SYNC_START);
   localparam logic [15:0] c_hs_end     = 16'(H_SYNC_START + H_SYNC_LEN);
   localparam logic [15:0] c_v_visible  = 16'(V_VISIBLE);
   localparam logic [15:0] c_v_last     = 16'(V_TOTAL - 1);
   localparam logic [15:0] c_vs_start   = 16'(V_SYNC_START);
   localparam logic [15:0] c_vs_end     = 16'(V_SYNC_START + V_SYNC_LEN);
   localparam logic [7:0]  c_lock_lines = 8'(LOCK_LINES);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      H_TRACK = 2'd1,
      V_WAIT  = 2'd2,
      LOCKED  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] hc_q, hc_d;
   logic [15:0] vc_q, vc_d;
   logic [7:0]  lock_cnt_q, lock_cnt_d;
   logic        hs_prev_q, hs_prev_d;
   logic        vs_prev_q, vs_prev_d;
   logic [15:0] h_address_q, h_address_d;
   logic [15:0] v_address_q, v_address_d;
   logic        locked_q, locked_d;
   logic        video_on_q, video_on_d;
   logic        frame_start_q, frame_start_d;
   logic        sync_err_q, sync_err_d;
   logic [7:0]  err_count_q, err_count_d;

   logic [15:0] w_hc_cur;
   logic [15:0] w_vc_cur;
   logic        w_h_fall;
   logic        w_v_fall;
   logic        w_exp_h;
   logic        w_exp_v;
   logic        w_err;

   // hc_q/vc_q hold the position of the sample currently on hsync/vsync;
   // w_hc_cur/w_vc_cur are the same position after any re-acquisition this cycle.
   always_comb begin
      w_h_fall   = hs_prev_q & ~bus.hsync;
      w_v_fall   = vs_prev_q & ~bus.vsync;
      w_exp_h    = ~((hc_q >= c_hs_start) && (hc_q < c_hs_end));
      w_exp_v    = ~((vc_q >= c_vs_start) && (vc_q < c_vs_end));
      w_hc_cur   = hc_q;
      w_vc_cur   = vc_q;
      w_err      = 1'b0;
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;

      case (state_q)
         SEARCH: begin
            if (w_h_fall) begin
               w_hc_cur   = c_hs_start;
               lock_cnt_d = '0;
               state_d    = H_TRACK;
            end
         end
         H_TRACK: begin
            if (bus.hsync != w_exp_h) begin
               w_err   = 1'b1;
               state_d = SEARCH;
            end else if (w_h_fall && (hc_q == c_hs_start)) begin
               lock_cnt_d = lock_cnt_q + 8'd1;
               if (lock_cnt_q + 8'd1 >= c_lock_lines) begin
                  state_d = V_WAIT;
               end
            end
         end
         V_WAIT: begin
            if (bus.hsync != w_exp_h) begin
               w_err   = 1'b1;
               state_d = SEARCH;
            end else if (w_v_fall) begin
               if (hc_q != 16'd0) begin
                  w_err   = 1'b1;
                  state_d = SEARCH;
               end else begin
                  w_vc_cur = c_vs_start;
                  state_d  = LOCKED;
               end
            end
         end
         LOCKED: begin
            if ((bus.hsync != w_exp_h) || (bus.vsync != w_exp_v)) begin
               w_err   = 1'b1;
               state_d = SEARCH;
            end
         end
         default: state_d = SEARCH;
      endcase

      if (w_hc_cur == c_h_last) begin
         hc_d = '0;
         vc_d = (w_vc_cur == c_v_last) ? 16'd0 : w_vc_cur + 16'd1;
      end else begin
         hc_d = w_hc_cur + 16'd1;
         vc_d = w_vc_cur;
      end

      hs_prev_d = bus.hsync;
      vs_prev_d = bus.vsync;

      // Outputs describe this sample using the state it leaves us in, so an
      // error sample already reports locked low alongside its sync_err pulse.
      locked_d      = (state_d == LOCKED);
      h_address_d   = locked_d ? w_hc_cur : 16'd0;
      v_address_d   = locked_d ? w_vc_cur : 16'd0;
      video_on_d    = locked_d && (w_hc_cur < c_h_visible) && (w_vc_cur < c_v_visible);
      frame_start_d = locked_d && (w_hc_cur == 16'd0) && (w_vc_cur == 16'd0);
      sync_err_d    = w_err;
      err_count_d   = err_count_q;
      if (w_err && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= SEARCH;
         hc_q          <= '0;
         vc_q          <= '0;
         lock_cnt_q    <= '0;
         hs_prev_q     <= 1'b1;
         vs_prev_q     <= 1'b1;
         h_address_q   <= '0;
         v_address_q   <= '0;
         locked_q      <= 1'b0;
         video_on_q    <= 1'b0;
         frame_start_q <= 1'b0;
         sync_err_q    <= 1'b0;
         err_count_q   <= '0;
      end else begin
         state_q       <= state_d;
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         lock_cnt_q    <= lock_cnt_d;
         hs_prev_q     <= hs_prev_d;
         vs_prev_q     <= vs_prev_d;
         h_address_q   <= h_address_d;
         v_address_q   <= v_address_d;
         locked_q      <= locked_d;
         video_on_q    <= video_on_d;
         frame_start_q <= frame_start_d;
         sync_err_q    <= sync_err_d;
         err_count_q   <= err_count_d;
      end
   end

   assign bus.H_address   = h_address_q;
   assign bus.V_address   = v_address_q;
   assign bus.locked      = locked_q;
   assign bus.video_on    = video_on_q;
   assign bus.frame_start = frame_start_q;
   assign bus.sync_err    = sync_err_q;
   assign bus.err_count   = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// tb_vga_sync_decoder : directed bench for vga_sync_decoder on a shrunken 12x10 raster
// Revision 1.0
// ============================================================================
module tb_vga_sync_decoder;
   localparam int HV  = 8;
   localparam int HT  = 12;
   localparam int HSS = 9;
   localparam int HSL = 2;
   localparam int VV  = 6;
   localparam int VT  = 10;
   localparam int VSS = 7;
   localparam int VSL = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   vga_sync_decoder_if bus();

   vga_sync_decoder #(
      .H_VISIBLE(HV), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
      .V_VISIBLE(VV), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
      .LOCK_LINES(2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad = 0;
   int   gh = 0, gv = 0;          // generator position of the next sample to drive
   int   ph = 0, pv = 0;          // position of the sample just taken
   int   h_period = HT;
   bit   h_force = 0, v_force = 0;
   logic h_val = 1'b1, v_val = 1'b1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one sample at negedge, let the DUT register it, then advance the generator.
   task automatic tick();
      @(negedge clk);
      bus.hsync = h_force ? h_val : !((gh >= HSS) && (gh < HSS + HSL));
      bus.vsync = v_force ? v_val : !((gv >= VSS) && (gv < VSS + VSL));
      ph = gh;
      pv = gv;
      @(posedge clk);
      #1;
      if (gh >= h_period - 1) begin
         gh = 0;
         gv = (gv == VT - 1) ? 0 : gv + 1;
      end else begin
         gh++;
      end
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      h_force = 0;
      v_force = 0;
      h_period = HT;
      tick();
      tick();
      reset = 1'b0;
      gh = 0;
      gv = 0;
      chk("reset_state", {bus.H_address, bus.V_address, bus.locked, bus.video_on,
                          bus.frame_start, bus.sync_err, bus.err_count}, 64'd0);
   endtask

   task automatic wait_lock(input int bound, input string tag, output int errs);
      int n;
      n = 0;
      errs = 0;
      while ((bus.locked !== 1'b1) && (n < bound)) begin
         tick();
         n++;
         if (bus.sync_err === 1'b1) errs++;
      end
      chk({tag, "_locked"}, bus.locked, 1);
      chk({tag, "_lock_h"}, bus.H_address, 0);
      chk({tag, "_lock_v"}, bus.V_address, VSS);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int errs;
      int n;
      int fs;
      int pulses;
      bit seen_lock;
      logic [35:0] exp_vec;
      logic        e_vid, e_fs;

      bus.hsync = 1'b1;
      bus.vsync = 1'b1;

      // Reset and first acquisition from a clean generator.
      do_reset();
      wait_lock(3 * HT + HT * VT, "lock1", errs);
      chk("lock1_no_err", errs, 0);
      chk("lock1_err_count", bus.err_count, 0);

      // Three locked frames: addresses follow the generator one cycle late.
      fs = 0;
      for (int i = 0; i < 3 * HT * VT; i++) begin
         tick();
         e_vid   = (ph < HV) && (pv < VV);
         e_fs    = (ph == 0) && (pv == 0);
         exp_vec = {16'(ph), 16'(pv), 1'b1, e_vid, e_fs, 1'b0};
         chk("track", {bus.H_address, bus.V_address, bus.locked, bus.video_on,
                       bus.frame_start, bus.sync_err}, {28'd0, exp_vec});
         if (bus.frame_start === 1'b1) fs++;
      end
      chk("frame_start_count", fs, 3);

      // Visible edge on the last visible line.
      n = 0;
      while (!((gh == HV - 1) && (gv == VV - 1)) && (n < 200)) begin tick(); n++; end
      tick();
      chk("vis_last_px", {bus.H_address, bus.V_address, bus.video_on}, {16'd7, 16'd5, 1'b1});
      tick();
      chk("vis_blank_px", {bus.H_address, bus.video_on}, {16'd8, 1'b0});

      // Glitch hsync high inside the sync pulse.
      n = 0;
      while ((gh != HSS + 1) && (n < 20)) begin tick(); n++; end
      chk("pre_glitch_locked", bus.locked, 1);
      h_force = 1;
      h_val   = 1'b1;
      tick();
      h_force = 0;
      chk("glitch_err", {bus.sync_err, bus.locked, bus.err_count}, {1'b1, 1'b0, 8'd1});
      tick();
      chk("glitch_pulse_1cyc", bus.sync_err, 0);
      wait_lock(2 * HT * VT, "relock2", errs);
      chk("relock2_no_err", errs, 0);

      // Vsync held low one line too long.
      n = 0;
      while (!((gh == 0) && (gv == VSS)) && (n < 130)) begin tick(); n++; end
      chk("pre_vlong_locked", bus.locked, 1);
      v_force = 1;
      v_val   = 1'b0;
      errs = 0;
      n = 0;
      while (n < 40) begin
         tick();
         n++;
         if ((ph == 0) && (pv == VSS + VSL)) break;
         if (bus.sync_err === 1'b1) errs++;
      end
      v_force = 0;
      chk("vlong_quiet", errs, 0);
      chk("vlong_err", {bus.sync_err, bus.locked, bus.err_count}, {1'b1, 1'b0, 8'd2});

      // Vsync fall off column 0 while waiting for vertical lock.
      do_reset();
      n = 0;
      while (!((gh == 5) && (gv == 3)) && (n < 60)) begin tick(); n++; end
      chk("vwait_not_locked", bus.locked, 0);
      v_force = 1;
      v_val   = 1'b0;
      tick();
      v_force = 0;
      chk("vwait_bad_fall", {bus.sync_err, bus.locked, bus.err_count}, {1'b1, 1'b0, 8'd1});
      wait_lock(2 * HT * VT, "relock5", errs);
      chk("relock5_no_err", errs, 0);

      // Line period one pixel too long: one error per line, never locks.
      do_reset();
      h_period = HT + 1;
      v_force  = 1;
      v_val    = 1'b1;
      pulses    = 0;
      seen_lock = 0;
      for (int i = 0; i < 10 * (HT + 1); i++) begin
         tick();
         if (bus.sync_err === 1'b1) pulses++;
         if (bus.locked !== 1'b0) seen_lock = 1;
      end
      chk("long_line_errs", pulses, 9);
      chk("long_line_count", bus.err_count, 9);
      chk("long_line_no_lock", seen_lock, 0);

      // Keep erring until well past saturation.
      n = 0;
      while ((pulses < 300) && (n < 5000)) begin
         tick();
         n++;
         if (bus.sync_err === 1'b1) pulses++;
      end
      chk("sat_pulse", bus.sync_err, 1);
      chk("sat_count", bus.err_count, 255);

      // Relock with the count saturated, then reset while locked.
      h_period = HT;
      v_force  = 0;
      gh = 0;
      gv = 0;
      wait_lock(3 * HT * VT, "relock7", errs);
      chk("relock7_count", bus.err_count, 255);
      reset = 1'b1;
      tick();
      chk("reset_mid_lock", {bus.H_address, bus.V_address, bus.locked, bus.video_on,
                             bus.frame_start, bus.sync_err, bus.err_count}, 64'd0);
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
